// File: rtl/m2u_push_arbiter_pkg.sv
// Shared constants for the M4-to-USB push arbiter: default widths,
// requester slot assignments and the round-robin pointer advance.
package m2u_push_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int IDX_W      = 2;

  localparam logic [IDX_W-1:0] REQ_WBS  = 2'd0;
  localparam logic [IDX_W-1:0] REQ_LOOP = 2'd1;
  localparam logic [IDX_W-1:0] REQ_PAT  = 2'd2;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input int num_req);
    rr_next = ((int'(idx) + 1) >= num_req) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/m2u_push_arbiter_if.sv
// Producer-side valid/ready bundle plus the M2U FIFO push port.
// The slave modport is the arbiter's view; master is the producers/FIFO side.
interface m2u_push_arbiter_if
  import m2u_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF
);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      FIFO_m2u_full;
  logic                      FIFO_m2u_af;
  logic                      FIFO_m2u_push;
  logic [DATA_W-1:0]         FIFO_m2u_din;

  modport slave (
    input  req_valid_i, req_data_i, FIFO_m2u_full, FIFO_m2u_af,
    output req_ready_o, FIFO_m2u_push, FIFO_m2u_din
  );

  modport master (
    output req_valid_i, req_data_i, FIFO_m2u_full, FIFO_m2u_af,
    input  req_ready_o, FIFO_m2u_push, FIFO_m2u_din
  );

endinterface

// File: rtl/m2u_push_arbiter_rr_arb_core.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Produces the one-hot grant, its index and an any-grant flag.
module rr_arb_core
  import m2u_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // Scan from farthest offset down so the nearest valid requester wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m2u_push_arbiter.sv
// Round-robin arbiter sharing the M2U FIFO push port among NUM_REQ byte
// producers, with registered push, FIFO throttling and push/stall statistics.
module m2u_push_arbiter
  import m2u_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              WBs_CLK_i,
  input  logic              WBs_RSTn_i,
  input  logic              enable_i,
  input  logic              cnt_clr_i,
  m2u_push_arbiter_if.slave bus,
  output logic [CNT_W-1:0]  push_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        last_grant_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  logic [IDX_W-1:0]   ptr_p1;
  logic               vld_p1;
  logic [DATA_W-1:0]  din_p1;

  logic               allow_p0;
  logic [NUM_REQ-1:0] req_p0;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [IDX_W-1:0]   idx_p0;
  logic               acc_p0;
  logic               stall_p0;
  logic [DATA_W-1:0]  sel_data_p0;

  // Stage p0: grant decision; under almost-full a gap cycle follows every push.
  assign allow_p0 = enable_i & ~bus.FIFO_m2u_full & ~(bus.FIFO_m2u_af & vld_p1);
  assign req_p0   = bus.req_valid_i & {NUM_REQ{allow_p0}};

  rr_arb_core #(.NUM_REQ(NUM_REQ)) u_rr_arb_core (
    .req (req_p0),
    .ptr (ptr_p1),
    .gnt (gnt_p0),
    .idx (idx_p0),
    .any (acc_p0)
  );

  assign bus.req_ready_o = WBs_RSTn_i ? gnt_p0 : '0;
  assign stall_p0        = enable_i & (|bus.req_valid_i) & ~(|bus.req_ready_o);
  assign sel_data_p0     = bus.req_data_i[int'(idx_p0)*DATA_W +: DATA_W];

  // Stage p1: registered push strobe/data, pointer and statistics.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      vld_p1       <= 1'b0;
      din_p1       <= '0;
      ptr_p1       <= '0;
      last_grant_o <= '0;
      push_cnt_o   <= '0;
      stall_cnt_o  <= '0;
    end else begin
      vld_p1 <= acc_p0;
      if (acc_p0) begin
        din_p1       <= sel_data_p0;
        ptr_p1       <= rr_next(idx_p0, NUM_REQ);
        last_grant_o <= idx_p0;
      end
      if (cnt_clr_i) begin
        push_cnt_o  <= '0;
        stall_cnt_o <= '0;
      end else begin
        if (vld_p1)   push_cnt_o  <= push_cnt_o + 1'b1;
        if (stall_p0) stall_cnt_o <= sat_inc(stall_cnt_o);
      end
    end
  end

  assign bus.FIFO_m2u_push = vld_p1;
  assign bus.FIFO_m2u_din  = din_p1;

endmodule

// File: tb/tb_m2u_push_arbiter.sv
// Directed bench for m2u_push_arbiter: two requesters, 4-bit counters so
// stall saturation is reachable in a few cycles.
module tb_m2u_push_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0]       last_grant;
  logic [7:0]       d0, d1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  m2u_push_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  assign bus.req_data_i = {d1, d0};

  m2u_push_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .WBs_CLK_i    (clk),
    .WBs_RSTn_i   (rst_n),
    .enable_i     (en),
    .cnt_clr_i    (clr),
    .bus          (bus.slave),
    .push_cnt_o   (push_cnt),
    .stall_cnt_o  (stall_cnt),
    .last_grant_o (last_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; d0 = 8'h41; d1 = 8'h00;
    bus.req_valid_i = 2'b01; bus.FIFO_m2u_full = 1'b0; bus.FIFO_m2u_af = 1'b0;
    #2;
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_push", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("rst_din", 32'(bus.FIFO_m2u_din), 32'h0);
    chk("rst_push_cnt", 32'(push_cnt), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_last_grant", 32'(last_grant), 32'h0);
    bus.req_valid_i = 2'b00;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // T1: single byte from requester 0
    bus.req_valid_i = 2'b01; d0 = 8'h41;
    #1 chk("t1_ready", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t1_push", 32'(bus.FIFO_m2u_push), 32'h1);
    chk("t1_din", 32'(bus.FIFO_m2u_din), 32'h41);
    chk("t1_push_cnt_lat", 32'(push_cnt), 32'h0);
    bus.req_valid_i = 2'b00;
    tick();
    chk("t1_push_off", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("t1_din_hold", 32'(bus.FIFO_m2u_din), 32'h41);
    chk("t1_push_cnt", 32'(push_cnt), 32'h1);
    chk("t1_last_grant", 32'(last_grant), 32'h0);

    // requester 1 alone, brings pointer back to 0
    bus.req_valid_i = 2'b10; d1 = 8'hC3;
    #1 chk("r1_ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("r1_din", 32'(bus.FIFO_m2u_din), 32'hC3);
    chk("r1_last_grant", 32'(last_grant), 32'h1);
    bus.req_valid_i = 2'b00;
    tick();
    chk("r1_push_cnt", 32'(push_cnt), 32'h2);

    // T2: both continuously valid, alternating grants
    bus.req_valid_i = 2'b11; d0 = 8'hA0; d1 = 8'hB0;
    #1 chk("t2_ready0", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t2_din0", 32'(bus.FIFO_m2u_din), 32'hA0);
    chk("t2_ready1", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("t2_din1", 32'(bus.FIFO_m2u_din), 32'hB0);
    chk("t2_ready2", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t2_din2", 32'(bus.FIFO_m2u_din), 32'hA0);
    chk("t2_ready3", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("t2_din3", 32'(bus.FIFO_m2u_din), 32'hB0);
    chk("t2_push3", 32'(bus.FIFO_m2u_push), 32'h1);
    chk("t2_push_cnt_mid", 32'(push_cnt), 32'h5);
    bus.req_valid_i = 2'b00;
    tick();
    chk("t2_push_off", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("t2_push_cnt", 32'(push_cnt), 32'h6);
    chk("t2_stall_cnt", 32'(stall_cnt), 32'h0);

    // T3: almost-full, one gap cycle after every push
    bus.FIFO_m2u_af = 1'b1; bus.req_valid_i = 2'b11;
    #1 chk("t3_ready0", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t3_push0", 32'(bus.FIFO_m2u_push), 32'h1);
    chk("t3_din0", 32'(bus.FIFO_m2u_din), 32'hA0);
    chk("t3_gap0_ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    chk("t3_gap0_push", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("t3_ready1", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("t3_push1", 32'(bus.FIFO_m2u_push), 32'h1);
    chk("t3_din1", 32'(bus.FIFO_m2u_din), 32'hB0);
    chk("t3_gap1_ready", 32'(bus.req_ready_o), 32'h0);
    tick();
    chk("t3_gap1_push", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("t3_ready2", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t3_din2", 32'(bus.FIFO_m2u_din), 32'hA0);
    bus.req_valid_i = 2'b00; bus.FIFO_m2u_af = 1'b0;
    tick();
    chk("t3_push_cnt", 32'(push_cnt), 32'h9);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'h2);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_push_cnt", 32'(push_cnt), 32'h0);
    chk("clr_stall_cnt", 32'(stall_cnt), 32'h0);

    // T4: full for 5 cycles, then grant at pointer (requester 1)
    bus.FIFO_m2u_full = 1'b1; bus.req_valid_i = 2'b11;
    #1 chk("t4_ready_full", 32'(bus.req_ready_o), 32'h0);
    repeat (5) tick();
    chk("t4_stall_cnt", 32'(stall_cnt), 32'h5);
    chk("t4_push_full", 32'(bus.FIFO_m2u_push), 32'h0);
    bus.FIFO_m2u_full = 1'b0;
    #1 chk("t4_ready_ptr", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("t4_din", 32'(bus.FIFO_m2u_din), 32'hB0);
    chk("t4_last_grant", 32'(last_grant), 32'h1);
    bus.req_valid_i = 2'b00;
    tick();
    chk("t4_push_cnt", 32'(push_cnt), 32'h1);
    chk("t4_stall_hold", 32'(stall_cnt), 32'h5);

    bus.FIFO_m2u_full = 1'b1; bus.req_valid_i = 2'b11;
    repeat (12) tick();
    chk("stall_sat", 32'(stall_cnt), 32'hF);
    bus.FIFO_m2u_full = 1'b0; bus.req_valid_i = 2'b00;

    // T5: reset while a push is pending
    bus.req_valid_i = 2'b01; d0 = 8'h5A;
    tick();
    chk("t5_pending_push", 32'(bus.FIFO_m2u_push), 32'h1);
    chk("t5_pending_din", 32'(bus.FIFO_m2u_din), 32'h5A);
    bus.req_valid_i = 2'b11; rst_n = 1'b0;
    #1;
    chk("t5_rst_push", 32'(bus.FIFO_m2u_push), 32'h0);
    chk("t5_rst_din", 32'(bus.FIFO_m2u_din), 32'h0);
    chk("t5_rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("t5_rst_push_cnt", 32'(push_cnt), 32'h0);
    chk("t5_rst_stall_cnt", 32'(stall_cnt), 32'h0);
    tick();
    rst_n = 1'b1; d0 = 8'hA0;
    #1 chk("t5_ptr_reset", 32'(bus.req_ready_o), 32'h1);
    tick();
    chk("t5_din", 32'(bus.FIFO_m2u_din), 32'hA0);
    chk("t5_push", 32'(bus.FIFO_m2u_push), 32'h1);

    // T6: clear beats a simultaneous push count; enable low blocks grants
    bus.req_valid_i = 2'b00; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t6_clr_push_cnt", 32'(push_cnt), 32'h0);
    en = 1'b0; bus.req_valid_i = 2'b11;
    #1 chk("t6_dis_ready", 32'(bus.req_ready_o), 32'h0);
    repeat (3) tick();
    chk("t6_dis_stall", 32'(stall_cnt), 32'h0);
    chk("t6_dis_push", 32'(bus.FIFO_m2u_push), 32'h0);
    en = 1'b1;
    #1 chk("t6_en_ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    chk("t6_en_din", 32'(bus.FIFO_m2u_din), 32'hB0);
    chk("t6_en_push", 32'(bus.FIFO_m2u_push), 32'h1);
    bus.req_valid_i = 2'b00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
